// File: rtl/dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : dma_controller
// Purpose  : Single-channel device-to-memory DMA engine. On a CPU command it
//            requests the memory bus, pulls qword beats from a device port and
//            writes them to consecutive qword-aligned addresses. After
//            MAX_GRANT beats it gives the bus back for one cycle before it
//            re-requests. A one-cycle interrupt marks completion.
// Ports    : clk_i, reset_i             - clock, asynchronous active-high reset
//            cmd_valid_i/cmd_ready_o    - command handshake (ready in IDLE only)
//            cmd_addr_i, cmd_len_i      - start word address, length in words
//            br_o, bg_i                 - bus request / bus grant
//            dev_valid_i, dev_data_i,
//            dev_ready_o                - device qword source
//            write_q_o, mem_addr_o,
//            mem_data_o, mem_ack_i      - memory write port
//            busy_o, dma_done_o         - status, completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module dma_controller #(
  parameter int WORD_SIZE  = 16,
  parameter int QWORD_SIZE = 64,
  parameter int MAX_GRANT  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  input  logic [WORD_SIZE-1:0]  cmd_addr_i,
  input  logic [WORD_SIZE-1:0]  cmd_len_i,
  output logic                  cmd_ready_o,
  output logic                  br_o,
  input  logic                  bg_i,
  input  logic                  dev_valid_i,
  input  logic [QWORD_SIZE-1:0] dev_data_i,
  output logic                  dev_ready_o,
  output logic                  write_q_o,
  output logic [WORD_SIZE-1:0]  mem_addr_o,
  output logic [QWORD_SIZE-1:0] mem_data_o,
  input  logic                  mem_ack_i,
  output logic                  busy_o,
  output logic                  dma_done_o
);

  localparam int BEAT_W = $clog2(MAX_GRANT + 1);

  localparam logic [BEAT_W-1:0]    MAX_BEAT    = BEAT_W'(MAX_GRANT);
  localparam logic [BEAT_W-1:0]    BEAT_ONE    = BEAT_W'(1);
  localparam logic [WORD_SIZE-1:0] QWORD_WORDS = WORD_SIZE'(4);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]            state_q,  state_d;
  logic [WORD_SIZE-1:0]  addr_q,   addr_d;
  logic [WORD_SIZE-1:0]  remain_q, remain_d;
  logic [BEAT_W-1:0]     beat_q,   beat_d;
  logic [QWORD_SIZE-1:0] data_q,   data_d;

  // Commands are qword granular: the two low bits of address and length are
  // dropped on entry.
  logic [WORD_SIZE-1:0] w_cmd_addr;
  logic [WORD_SIZE-1:0] w_cmd_remain;
  logic                 w_unused_low_bits;

  assign w_cmd_addr        = {cmd_addr_i[WORD_SIZE-1:2], 2'b00};
  assign w_cmd_remain      = {cmd_len_i[WORD_SIZE-1:2], 2'b00};
  assign w_unused_low_bits = ^{cmd_addr_i[1:0], cmd_len_i[1:0]};

  // Post-write values; address arithmetic wraps naturally at 2^WORD_SIZE.
  logic [WORD_SIZE-1:0] w_addr_inc;
  logic [WORD_SIZE-1:0] w_remain_dec;
  logic [BEAT_W-1:0]    w_beat_inc;
  logic                 w_write_ack;
  logic                 w_fetch_take;

  assign w_addr_inc   = addr_q + QWORD_WORDS;
  assign w_remain_dec = remain_q - QWORD_WORDS;
  assign w_beat_inc   = beat_q + BEAT_ONE;
  // An ack only counts while the strobe is actually out, i.e. with grant held.
  assign w_write_ack  = mem_ack_i & bg_i;
  assign w_fetch_take = dev_valid_i & bg_i;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      beat_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      beat_q   <= beat_d;
      data_q   <= data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    beat_d   = beat_q;
    data_d   = data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d   = w_cmd_addr;
          remain_d = w_cmd_remain;
          beat_d   = '0;
          // Sub-qword lengths complete without ever touching the bus.
          state_d  = (w_cmd_remain != '0) ? S_REQ : S_DONE;
        end
      end

      S_REQ: begin
        if (bg_i) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (w_fetch_take) begin
          data_d  = dev_data_i;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        // Losing the grant simply holds address and data; the same write is
        // reissued once grant returns.
        if (w_write_ack) begin
          addr_d   = w_addr_inc;
          remain_d = w_remain_dec;
          if (w_remain_dec == '0) begin
            beat_d  = w_beat_inc;
            state_d = S_DONE;
          end else if (w_beat_inc == MAX_BEAT) begin
            beat_d  = '0;
            state_d = S_RELEASE;
          end else begin
            beat_d  = w_beat_inc;
            state_d = S_FETCH;
          end
        end
      end

      S_RELEASE: begin
        state_d = S_REQ;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    br_o        = 1'b0;
    dev_ready_o = 1'b0;
    write_q_o   = 1'b0;
    dma_done_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_REQ: begin
        br_o = 1'b1;
      end
      S_FETCH: begin
        br_o        = 1'b1;
        dev_ready_o = bg_i;
      end
      S_WRITE: begin
        br_o      = 1'b1;
        write_q_o = bg_i;
      end
      S_RELEASE: begin
        br_o = 1'b0;
      end
      S_DONE: begin
        dma_done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_controller
// Purpose  : Directed self-checking bench for dma_controller. A cycle helper
//            plays CPU grant logic (grant one cycle after request), an always
//            valid device, and a zero-latency memory, and logs every
//            acknowledged write for comparison with hand-computed addresses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_controller;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_ready;
  logic        br;
  logic        bg;
  logic        dev_valid;
  logic [63:0] dev_data;
  logic        dev_ready;
  logic        write_q;
  logic [15:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_ack;
  logic        busy;
  logic        dma_done;

  dma_controller #(
    .WORD_SIZE  (16),
    .QWORD_SIZE (64),
    .MAX_GRANT  (4)
  ) u_dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .cmd_valid_i (cmd_valid),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .cmd_ready_o (cmd_ready),
    .br_o        (br),
    .bg_i        (bg),
    .dev_valid_i (dev_valid),
    .dev_data_i  (dev_data),
    .dev_ready_o (dev_ready),
    .write_q_o   (write_q),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .mem_ack_i   (mem_ack),
    .busy_o      (busy),
    .dma_done_o  (dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Per-transfer observation state
  logic [15:0] la [16];
  logic [63:0] ld [16];
  int  n_wr;
  int  done_cnt;
  int  rel_cnt;
  int  overlap;
  int  cyc;
  int  last_ack_cyc;
  int  done_cyc;
  int  done_br;
  int  br_seen;
  int  dev_k;
  int  stall_cnt;
  int  stall_wq;
  int  stall_hit;
  bit  stall_arm;
  bit  spam_cmd;
  logic br_prev;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pattern(input int k);
    logic [15:0] w;
    w = 16'(k);
    return {w + 16'h1111, w ^ 16'hA5A5, 16'hC0DE, ~w};
  endfunction

  // One clock of environment behaviour, evaluated at the falling edge.
  task automatic tick();
    bit stalling;
    @(negedge clk);
    cyc++;
    cmd_valid = spam_cmd;
    stalling  = (stall_cnt > 0);
    if (stall_cnt > 0) stall_cnt--;
    bg        = br & br_prev & !stalling;
    br_prev   = br;
    dev_valid = 1'b1;
    dev_data  = pattern(dev_k);
    #1;
    // Stray acks during the stall must be ignored by the DUT.
    mem_ack = write_q | stalling;
    if (stall_arm && write_q && mem_addr == 16'h0104) begin
      stall_arm = 1'b0;
      stall_hit++;
      stall_cnt = 3;
      mem_ack   = 1'b0;
    end
    if (stalling && write_q) stall_wq++;
    if (write_q && dev_ready) overlap++;
    if (write_q && mem_ack) begin
      if (n_wr < 16) begin
        la[n_wr] = mem_addr;
        ld[n_wr] = mem_data;
      end
      n_wr++;
      last_ack_cyc = cyc;
    end
    if (dev_ready) dev_k++;
    if (br) br_seen++;
    if (busy && !br && !dma_done) rel_cnt++;
    if (dma_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_br  = int'(br);
    end
  endtask

  task automatic clear_obs();
    n_wr = 0; done_cnt = 0; rel_cnt = 0; overlap = 0; cyc = 0;
    last_ack_cyc = -10; done_cyc = -1; done_br = 0; br_seen = 0;
    dev_k = 0; stall_cnt = 0; stall_wq = 0; stall_hit = 0;
  endtask

  task automatic run_cmd(input logic [15:0] a, input logic [15:0] l, input bit spam, input int budget);
    int steps;
    clear_obs();
    @(negedge clk);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    spam_cmd  = spam;
    tick();
    // A held command with different contents must not be picked up mid-run.
    cmd_addr = 16'h5550;
    cmd_len  = 16'd40;
    steps = 0;
    while (done_cnt == 0 && steps < budget) begin
      tick();
      steps++;
    end
    spam_cmd = 1'b0;
    tick();
  endtask

  task automatic verify(input string tag, input int exp_n, input logic [15:0] base, input int exp_rel);
    logic [15:0] ea;
    check_eq({tag, "_nwr"}, 64'(n_wr), 64'(exp_n));
    for (int i = 0; i < exp_n && i < 16; i++) begin
      ea = base + 16'(4 * i);
      check_eq($sformatf("%s_addr%0d", tag, i), 64'(la[i]), 64'(ea));
      check_eq($sformatf("%s_data%0d", tag, i), ld[i], pattern(i));
    end
    check_eq({tag, "_done"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_release"}, 64'(rel_cnt), 64'(exp_rel));
    check_eq({tag, "_overlap"}, 64'(overlap), 64'd0);
    check_eq({tag, "_done_br"}, 64'(done_br), 64'd0);
    if (exp_n > 0) check_eq({tag, "_done_lat"}, 64'(done_cyc - last_ack_cyc), 64'd1);
    check_eq({tag, "_idle_ready"}, 64'(cmd_ready), 64'd1);
    check_eq({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int steps;
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    bg = 1'b0; dev_valid = 1'b0; dev_data = '0; mem_ack = 1'b0;
    br_prev = 1'b0; spam_cmd = 1'b0; stall_arm = 1'b0;
    clear_obs();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_busy",      64'(busy),      64'd0);
    check_eq("rst_br",        64'(br),        64'd0);
    check_eq("rst_write_q",   64'(write_q),   64'd0);
    check_eq("rst_dev_ready", 64'(dev_ready), 64'd0);
    check_eq("rst_done",      64'(dma_done),  64'd0);
    check_eq("rst_mem_addr",  64'(mem_addr),  64'd0);
    check_eq("rst_mem_data",  mem_data,       64'd0);
    reset = 1'b0;

    // Unaligned start, three beats, command held high throughout
    run_cmd(16'h01F6, 16'd12, 1'b1, 100);
    verify("basic", 3, 16'h01F4, 0);

    // Sub-qword length: straight to DONE without a bus request
    run_cmd(16'h0010, 16'h0003, 1'b0, 20);
    verify("short", 0, 16'h0010, 0);
    check_eq("short_no_br", 64'(br_seen), 64'd0);
    check_eq("short_lat",   64'(done_cyc), 64'd1);

    // Six beats: release for one cycle after the fourth
    run_cmd(16'h0040, 16'd24, 1'b0, 200);
    verify("grant", 6, 16'h0040, 1);

    // Exactly MAX_GRANT beats finishes without a release
    run_cmd(16'h0080, 16'd16, 1'b0, 200);
    verify("exact", 4, 16'h0080, 0);

    // Grant dropped for three cycles while writing 0x0104
    stall_arm = 1'b1;
    run_cmd(16'h0100, 16'd12, 1'b0, 200);
    verify("stall", 3, 16'h0100, 0);
    check_eq("stall_hit", 64'(stall_hit), 64'd1);
    check_eq("stall_wq",  64'(stall_wq),  64'd0);
    stall_arm = 1'b0;

    // Address wrap at the top of memory
    run_cmd(16'hFFFC, 16'd8, 1'b0, 100);
    verify("wrap", 2, 16'hFFFC, 0);

    // Reset during the second FETCH of an 8-word transfer
    clear_obs();
    @(negedge clk);
    cmd_addr = 16'h0200; cmd_len = 16'd8; cmd_valid = 1'b1;
    steps = 0;
    while (n_wr < 1 && steps < 50) begin
      tick();
      steps++;
    end
    tick();
    check_eq("midrst_in_fetch", 64'(dev_ready), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("midrst_br",        64'(br),        64'd0);
    check_eq("midrst_dev_ready", 64'(dev_ready), 64'd0);
    check_eq("midrst_write_q",   64'(write_q),   64'd0);
    check_eq("midrst_busy",      64'(busy),      64'd0);
    check_eq("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("midrst_mem_addr",  64'(mem_addr),  64'd0);
    check_eq("midrst_mem_data",  mem_data,       64'd0);
    tick();
    tick();
    tick();
    check_eq("midrst_no_done", 64'(done_cnt), 64'd0);
    reset = 1'b0;
    run_cmd(16'h0300, 16'd4, 1'b0, 100);
    verify("after_rst", 1, 16'h0300, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
